// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the SRAM and the cache array.
// The controller connects through the slave modport and the environment
// (pipeline, SRAM model, cache array) through the master modport.
interface cache_controller_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read;
    logic        sram_write;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [9:0]  cache_tag;
    logic [5:0]  cache_index;
    logic [2:0]  cache_offset;
    logic [31:0] cache_wdata;
    logic [63:0] cache_rdata;
    logic        write_cacheR;
    logic        write_cacheW;
    logic        cache_hit;
    logic [63:0] cache_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
               cache_hit, cache_data,
        input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write,
               cache_tag, cache_index, cache_offset, cache_wdata, cache_rdata,
               write_cacheR, write_cacheW, hit_count, miss_count
    );

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
               cache_hit, cache_data,
        output rdata, ready, sram_address, sram_wdata, sram_read, sram_write,
               cache_tag, cache_index, cache_offset, cache_wdata, cache_rdata,
               write_cacheR, write_cacheW, hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate cache controller sitting between the
// MEM stage and a 64-bit-line SRAM. Load hits finish in the request cycle;
// load misses fetch a full line and fill the cache; stores update the cache
// word in the request cycle and write the word through to SRAM.
module cache_controller (
    input logic              clk,
    input logic              rst,
    cache_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

    state_t      state;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [31:0] line_addr;
    logic        load_hit;
    logic        load_miss;

    // Pick the 32-bit word of a 64-bit line addressed by offset bit 2.
    function automatic logic [31:0] word_sel(input logic [63:0] line, input logic hi);
        return hi ? line[63:32] : line[31:0];
    endfunction

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    assign line_addr        = {bus.address[31:3], 3'b000};
    assign bus.cache_tag    = bus.address[18:9];
    assign bus.cache_index  = bus.address[8:3];
    assign bus.cache_offset = bus.address[2:0];
    assign bus.cache_wdata  = bus.wdata;
    assign bus.cache_rdata  = bus.sram_rdata;
    assign bus.sram_wdata   = bus.wdata;
    assign bus.hit_count    = hit_cnt;
    assign bus.miss_count   = miss_cnt;

    // A store takes priority, so a load only counts when no store is present.
    assign load_hit  = (state == IDLE) && bus.MEM_R_EN && !bus.MEM_W_EN && bus.cache_hit;
    assign load_miss = (state == IDLE) && bus.MEM_R_EN && !bus.MEM_W_EN && !bus.cache_hit;

    // State transitions and saturating hit/miss statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else begin
            if (load_hit)
                hit_cnt <= sat_inc(hit_cnt);
            if (load_miss)
                miss_cnt <= sat_inc(miss_cnt);
            unique case (state)
                IDLE: begin
                    if (bus.MEM_W_EN)
                        state <= WRITE;
                    else if (load_miss)
                        state <= RMISS;
                end
                RMISS: if (bus.sram_ready) state <= IDLE;
                WRITE: if (bus.sram_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake, strobe and load-data outputs decoded from state and inputs;
    // everything is held quiet while reset is asserted.
    always_comb begin
        bus.ready        = 1'b0;
        bus.rdata        = 32'd0;
        bus.sram_read    = 1'b0;
        bus.sram_write   = 1'b0;
        bus.write_cacheR = 1'b0;
        bus.write_cacheW = 1'b0;
        bus.sram_address = bus.address;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bus.MEM_W_EN) begin
                        bus.write_cacheW = 1'b1;
                        bus.sram_write   = 1'b1;
                    end else if (bus.MEM_R_EN) begin
                        if (bus.cache_hit) begin
                            bus.ready = 1'b1;
                            bus.rdata = word_sel(bus.cache_data, bus.address[2]);
                        end else begin
                            bus.sram_read    = 1'b1;
                            bus.sram_address = line_addr;
                        end
                    end else begin
                        bus.ready = 1'b1;
                    end
                end
                RMISS: begin
                    bus.sram_read    = 1'b1;
                    bus.sram_address = line_addr;
                    if (bus.sram_ready) begin
                        bus.write_cacheR = 1'b1;
                        bus.ready        = 1'b1;
                        bus.rdata        = word_sel(bus.sram_rdata, bus.address[2]);
                    end
                end
                WRITE: begin
                    bus.sram_write = 1'b1;
                    if (bus.sram_ready)
                        bus.ready = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: load hit, load miss with line fill,
// write-through store, store/load collision, reset mid-miss and counter
// saturation. Inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_cache_controller;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    cache_controller_if bus ();

    cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst            = 1'b1;
        bus.address    = 32'd0;
        bus.wdata      = 32'd0;
        bus.MEM_R_EN   = 1'b0;
        bus.MEM_W_EN   = 1'b0;
        bus.sram_rdata = 64'd0;
        bus.sram_ready = 1'b0;
        bus.cache_hit  = 1'b0;
        bus.cache_data = 64'd0;

        // Reset: strobes forced low even with a load hit presented.
        step();
        bus.MEM_R_EN = 1'b1; bus.cache_hit = 1'b1; bus.address = 32'h208;
        step(); #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_sram_read", bus.sram_read, 0);
        chk("rst_hit_count", bus.hit_count, 0);
        chk("rst_miss_count", bus.miss_count, 0);
        bus.MEM_R_EN = 1'b0; bus.cache_hit = 1'b0;
        step();
        rst = 1'b0;

        // Load hit at 0x208, low word selected.
        step();
        bus.address = 32'h208; bus.MEM_R_EN = 1'b1; bus.cache_hit = 1'b1;
        bus.cache_data = 64'hAAAA5555_11112222;
        #1;
        chk("hit_ready", bus.ready, 1);
        chk("hit_rdata", bus.rdata, 32'h11112222);
        chk("hit_sram_read", bus.sram_read, 0);
        chk("hit_tag", bus.cache_tag, 10'd1);
        chk("hit_index", bus.cache_index, 6'd1);
        chk("hit_offset", bus.cache_offset, 3'd0);
        step();
        bus.MEM_R_EN = 1'b0; bus.cache_hit = 1'b0;
        #1;
        chk("hit_count_1", bus.hit_count, 16'd1);
        chk("idle_rdata_zero", bus.rdata, 32'd0);
        chk("idle_ready", bus.ready, 1);

        // Load miss at 0x20C, high word of the fetched line returned.
        step();
        bus.address = 32'h20C; bus.MEM_R_EN = 1'b1; bus.cache_hit = 1'b0;
        bus.sram_rdata = 64'hDEADBEEF_CAFEF00D; bus.sram_ready = 1'b0;
        #1;
        chk("miss_c0_ready", bus.ready, 0);
        chk("miss_c0_sram_read", bus.sram_read, 1);
        chk("miss_c0_sram_addr", bus.sram_address, 32'h208);
        for (int i = 1; i < 4; i++) begin
            step(); #1;
            chk("miss_wait_ready", bus.ready, 0);
            chk("miss_wait_sram_read", bus.sram_read, 1);
            chk("miss_wait_sram_addr", bus.sram_address, 32'h208);
            chk("miss_wait_fill", bus.write_cacheR, 0);
        end
        chk("miss_count_1", bus.miss_count, 16'd1);
        step();
        bus.sram_ready = 1'b1;
        #1;
        chk("miss_fill", bus.write_cacheR, 1);
        chk("miss_rdata", bus.rdata, 32'hDEADBEEF);
        chk("miss_ready", bus.ready, 1);
        chk("miss_cache_rdata", bus.cache_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("miss_no_wordw", bus.write_cacheW, 0);
        step();
        bus.MEM_R_EN = 1'b0; bus.sram_ready = 1'b0;
        #1;
        chk("miss_back_idle", bus.sram_read, 0);
        chk("miss_back_ready", bus.ready, 1);
        chk("miss_count_held", bus.miss_count, 16'd1);

        // Store at 0x100, write-through.
        step();
        bus.address = 32'h100; bus.wdata = 32'h12345678; bus.MEM_W_EN = 1'b1;
        #1;
        chk("st_c0_wordw", bus.write_cacheW, 1);
        chk("st_c0_sram_write", bus.sram_write, 1);
        chk("st_c0_ready", bus.ready, 0);
        chk("st_c0_sram_addr", bus.sram_address, 32'h100);
        chk("st_c0_sram_wdata", bus.sram_wdata, 32'h12345678);
        chk("st_c0_cache_wdata", bus.cache_wdata, 32'h12345678);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            chk("st_wait_wordw", bus.write_cacheW, 0);
            chk("st_wait_sram_write", bus.sram_write, 1);
            chk("st_wait_ready", bus.ready, 0);
            chk("st_wait_sram_addr", bus.sram_address, 32'h100);
        end
        step();
        bus.sram_ready = 1'b1;
        #1;
        chk("st_done_ready", bus.ready, 1);
        chk("st_done_wordw", bus.write_cacheW, 0);
        chk("st_done_fill", bus.write_cacheR, 0);
        step();
        bus.MEM_W_EN = 1'b0; bus.sram_ready = 1'b0;
        #1;
        chk("st_back_idle", bus.sram_write, 0);
        chk("st_back_ready", bus.ready, 1);

        // Load and store together: store wins, no counter movement.
        step();
        bus.address = 32'h208; bus.MEM_R_EN = 1'b1; bus.MEM_W_EN = 1'b1; bus.cache_hit = 1'b1;
        #1;
        chk("both_sram_read", bus.sram_read, 0);
        chk("both_sram_write", bus.sram_write, 1);
        chk("both_wordw", bus.write_cacheW, 1);
        chk("both_ready", bus.ready, 0);
        step();
        bus.sram_ready = 1'b1;
        #1;
        chk("both_done_ready", bus.ready, 1);
        chk("both_done_sram_read", bus.sram_read, 0);
        step();
        bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; bus.cache_hit = 1'b0; bus.sram_ready = 1'b0;
        #1;
        chk("both_hit_count", bus.hit_count, 16'd1);
        chk("both_miss_count", bus.miss_count, 16'd1);

        // Stray sram_ready in IDLE is ignored.
        step();
        bus.sram_ready = 1'b1;
        #1;
        chk("idle_ack_fill", bus.write_cacheR, 0);
        chk("idle_ack_rdata", bus.rdata, 32'd0);
        step();
        bus.sram_ready = 1'b0;
        #1;
        chk("idle_ack_stays", bus.sram_write | bus.sram_read, 0);
        chk("idle_ack_ready", bus.ready, 1);

        // Reset during a miss: abandoned, no fill, back to IDLE.
        step();
        bus.address = 32'h20C; bus.MEM_R_EN = 1'b1; bus.cache_hit = 1'b0;
        step(); #1;
        chk("rmiss_pre_rst_read", bus.sram_read, 1);
        chk("rmiss_pre_rst_misses", bus.miss_count, 16'd2);
        step();
        rst = 1'b1; bus.sram_ready = 1'b1;
        #1;
        chk("rmiss_rst_read", bus.sram_read, 0);
        chk("rmiss_rst_fill", bus.write_cacheR, 0);
        chk("rmiss_rst_ready", bus.ready, 0);
        step();
        rst = 1'b0; bus.MEM_R_EN = 1'b0; bus.sram_ready = 1'b0;
        #1;
        chk("rmiss_after_idle", bus.sram_read, 0);
        chk("rmiss_after_ready", bus.ready, 1);
        chk("rmiss_after_hits", bus.hit_count, 16'd0);
        chk("rmiss_after_misses", bus.miss_count, 16'd0);

        // Hit counter saturation: 65534 hits reach 0xFFFE, then it sticks at 0xFFFF.
        step();
        bus.address = 32'h208; bus.MEM_R_EN = 1'b1; bus.cache_hit = 1'b1;
        repeat (65534) step();
        #1;
        chk("sat_fffe", bus.hit_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("sat_ffff", bus.hit_count, 16'hFFFF);
        end
        bus.MEM_R_EN = 1'b0; bus.cache_hit = 1'b0;
        step(); #1;
        chk("sat_hold", bus.hit_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Single clock domain; reset synchronous, active-high (already decided).
REQ-002 Ports, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- address  in  32  MEM-stage byte address
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- rdata  out  32  load result
- ready  out  1  1 = request complete; 0 = freeze pipeline
- sram_address  out  32  SRAM address
- sram_wdata  out  32  SRAM store data
- sram_read  out  1  SRAM 64-bit line read request
- sram_write  out  1  SRAM 32-bit word write request
- sram_rdata  in  64  SRAM line data, valid when sram_ready
- sram_ready  in  1  SRAM completion strobe
- cache_tag  out  10  = address[18:9]
- cache_index  out  6  = address[8:3]
- cache_offset  out  3  = address[2:0]
- cache_wdata  out  32  = wdata
- cache_rdata  out  64  = sram_rdata
- write_cacheR  out  1  line fill strobe
- write_cacheW  out  1  word update strobe
- cache_hit  in  1  cache tag match
- cache_data  in  64  cache line on hit
- hit_count  out  16  saturating load-hit counter
- miss_count  out  16  saturating load-miss counter

Function
REQ-003 State register: IDLE, RMISS, WRITE; outputs combinational from state and inputs.
REQ-004 Word select: offset[2]=1 -> bits [63:32]; else [31:0]; applies to cache_data and sram_rdata.
REQ-005 IDLE, no request: ready=1, all strobes 0, stay IDLE.
REQ-006 IDLE, MEM_W_EN=1 (priority over MEM_R_EN): write_cacheW=1 this cycle only; sram_write=1; ready=0; next state WRITE.
REQ-007 IDLE, MEM_R_EN=1, cache_hit=1: rdata = selected cache_data word; ready=1 same cycle; hit_count+1; stay IDLE.
REQ-008 IDLE, MEM_R_EN=1, cache_hit=0: sram_read=1; ready=0; miss_count+1; next state RMISS.
REQ-009 RMISS: sram_read=1 held; sram_address = {address[31:3],3'b000}; on sram_ready=1: write_cacheR=1, rdata = selected sram_rdata word, ready=1, next IDLE; else stay.
REQ-010 WRITE: sram_write=1 held; sram_address = address; on sram_ready=1: ready=1, next IDLE; else stay; write_cacheW=0.
REQ-011 Write-through, no write-allocate: store miss leaves cache unchanged.
REQ-012 sram_read and sram_write never both 1; write_cacheR and write_cacheW never both 1.
REQ-013 sram_ready ignored in IDLE.
REQ-014 Counters saturate at 16'hFFFF; no wrap.
REQ-015 rdata = 0 when no load completes that cycle.

Reset
REQ-016 rst=1 at clock edge: state<=IDLE, hit_count<=0, miss_count<=0.
REQ-017 While rst=1: ready, sram_read, sram_write, write_cacheR, write_cacheW forced 0.
REQ-018 rst mid-RMISS/WRITE: transaction abandoned, no cache fill; IDLE next cycle.

Verification
REQ-019 Load hit: address=0x208, cache_hit=1, cache_data=0xAAAA5555_11112222 -> same cycle ready=1, rdata=0x11112222, hit_count=1.
REQ-020 Load miss: address=0x20C, cache_hit=0, sram_ready after 4 cycles, sram_rdata=0xDEADBEEF_CAFEF00D -> ready=0 for 4 cycles, sram_address=0x208, then write_cacheR=1, rdata=0xDEADBEEF, ready=1, miss_count=1.
REQ-021 Store: address=0x100, wdata=0x12345678, MEM_W_EN=1 -> write_cacheW=1 first cycle only, sram_write=1 until sram_ready, sram_address=0x100, then ready=1.
REQ-022 MEM_R_EN=MEM_W_EN=1 -> store path taken, sram_read=0, counters unchanged.
REQ-023 rst=1 during RMISS (cycle 2) -> strobes 0 that cycle, IDLE next, counters 0, no write_cacheR.
REQ-024 Force hit_count=16'hFFFE, three load hits -> 16'hFFFF, held.
